// File: rtl/hd44780_byte_sender_pkg.sv
// Shared timing defaults and FSM state encoding for the HD44780 4-bit byte sender.
package hd44780_byte_sender_pkg;

  // Default nybble timing in clocks at the build clock rate
  localparam int unsigned H4NS_TICKS_TAS   = 3;
  localparam int unsigned H4NS_TICKS_PWEH  = 22;
  localparam int unsigned H4NS_TICKS_TCYCE = 48;
  localparam int unsigned H4NS_COUNT_BITS  = 6;
  localparam int unsigned H4_DELAY_53US    = 2544;
  localparam int unsigned H4_EXEC_BITS     = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EHIGH = 3'd2,
    ST_ELOW  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/hd44780_byte_sender_if.sv
// Upstream request/completion bundle between the LCD sequencer and the byte sender.
interface hd44780_byte_sender_if;
  // start_strobe is a one-clock request taken only while the sender is idle (or in its
  // completion clock); requests during busy are dropped, never queued. DAT_I/rs_i/nyb_only_i
  // are captured on the accepting edge. end_strobe pulses for one clock when the byte and
  // its execution wait are finished.
  logic [7:0] DAT_I;
  logic       rs_i;
  logic       nyb_only_i;
  logic       start_strobe;
  logic       busy;
  logic       end_strobe;

  modport master (
    output DAT_I, rs_i, nyb_only_i, start_strobe,
    input  busy, end_strobe
  );

  modport slave (
    input  DAT_I, rs_i, nyb_only_i, start_strobe,
    output busy, end_strobe
  );
endinterface

// File: rtl/hd44780_byte_sender_tick_counter.sv
// Loadable down-counter; done is high while the count sits at 1 (last clock of a phase).
module hd44780_byte_sender_tick_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/hd44780_byte_sender.sv
// Sends one byte (high nybble first) or a lone high nybble over the HD44780 4-bit bus,
// then waits out the command execution time before signalling completion.
module hd44780_byte_sender
  import hd44780_byte_sender_pkg::*;
#(
  parameter int unsigned TICKS_TAS   = H4NS_TICKS_TAS,
  parameter int unsigned TICKS_PWEH  = H4NS_TICKS_PWEH,
  parameter int unsigned TICKS_TCYCE = H4NS_TICKS_TCYCE,
  parameter int unsigned COUNT_BITS  = H4NS_COUNT_BITS,
  parameter int unsigned TICKS_EXEC  = H4_DELAY_53US,
  parameter int unsigned EXEC_BITS   = H4_EXEC_BITS
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  hd44780_byte_sender_if.slave    up,
  output logic                    lcd_rs,
  output logic                    lcd_e,
  output logic [3:0]              lcd_data,
  output state_e                  dbg_state
);

  localparam int unsigned TICKS_ELOW = TICKS_TCYCE - TICKS_TAS - TICKS_PWEH;

  state_e          state_q, state_d;
  logic [3:0]      dat_lo_q, dat_lo_d;
  logic            nyb_only_q, nyb_only_d;
  logic            second_q, second_d;
  logic            busy_q, busy_d;
  logic            end_q, end_d;
  logic            lcd_e_q, lcd_e_d;
  logic            lcd_rs_q, lcd_rs_d;
  logic [3:0]      lcd_data_q, lcd_data_d;
  logic            ph_load, ph_done, ex_load, ex_done;
  logic [COUNT_BITS-1:0] ph_val;

  hd44780_byte_sender_tick_counter #(.WIDTH(COUNT_BITS)) u_phase_cnt (
    .clk(CLK_I), .rst_n(RST_I), .load(ph_load), .load_val(ph_val), .done(ph_done)
  );

  hd44780_byte_sender_tick_counter #(.WIDTH(EXEC_BITS)) u_exec_cnt (
    .clk(CLK_I), .rst_n(RST_I), .load(ex_load), .load_val(EXEC_BITS'(TICKS_EXEC)),
    .done(ex_done)
  );

  always_comb begin
    state_d    = state_q;
    dat_lo_d   = dat_lo_q;
    nyb_only_d = nyb_only_q;
    second_d   = second_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_data_d = lcd_data_q;
    ph_load    = 1'b0;
    ph_val     = COUNT_BITS'(TICKS_TAS);
    ex_load    = 1'b0;
    unique case (state_q)
      // The completion clock accepts a new request so transfers can run back to back
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (up.start_strobe) begin
          state_d    = ST_SETUP;
          dat_lo_d   = up.DAT_I[3:0];
          nyb_only_d = up.nyb_only_i;
          second_d   = 1'b0;
          lcd_rs_d   = up.rs_i;
          lcd_data_d = up.DAT_I[7:4];
          ph_load    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (ph_done) begin
          state_d = ST_EHIGH;
          ph_load = 1'b1;
          ph_val  = COUNT_BITS'(TICKS_PWEH);
        end
      end
      ST_EHIGH: begin
        if (ph_done) begin
          state_d = ST_ELOW;
          ph_load = 1'b1;
          ph_val  = COUNT_BITS'(TICKS_ELOW);
        end
      end
      ST_ELOW: begin
        if (ph_done) begin
          if (!nyb_only_q && !second_q) begin
            state_d    = ST_SETUP;
            second_d   = 1'b1;
            lcd_data_d = dat_lo_q;
            ph_load    = 1'b1;
          end else if (TICKS_EXEC != 0) begin
            state_d = ST_EXEC;
            ex_load = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_EXEC: begin
        if (ex_done) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state register
    busy_d  = (state_d == ST_SETUP) || (state_d == ST_EHIGH) ||
              (state_d == ST_ELOW)  || (state_d == ST_EXEC);
    lcd_e_d = (state_d == ST_EHIGH);
    end_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q    <= ST_IDLE;
      dat_lo_q   <= 4'h0;
      nyb_only_q <= 1'b0;
      second_q   <= 1'b0;
      busy_q     <= 1'b0;
      end_q      <= 1'b0;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      dat_lo_q   <= dat_lo_d;
      nyb_only_q <= nyb_only_d;
      second_q   <= second_d;
      busy_q     <= busy_d;
      end_q      <= end_d;
      lcd_e_q    <= lcd_e_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_data_q <= lcd_data_d;
    end
  end

  assign up.busy       = busy_q;
  assign up.end_strobe = end_q;
  assign lcd_e         = lcd_e_q;
  assign lcd_rs        = lcd_rs_q;
  assign lcd_data      = lcd_data_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_hd44780_byte_sender.sv
// Bench for the HD44780 byte sender: default-timing and short-timing instances checked
// cycle by cycle against a waveform model derived from the nybble timing rules.
module tb_hd44780_byte_sender;
  import hd44780_byte_sender_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a_n, rst_b_n;

  // ---------------- DUTs ----------------
  hd44780_byte_sender_if if_a ();
  hd44780_byte_sender_if if_b ();
  logic       lcd_rs_a, lcd_e_a, lcd_rs_b, lcd_e_b;
  logic [3:0] lcd_data_a, lcd_data_b;
  state_e     dbg_a, dbg_b;

  hd44780_byte_sender u_a (
    .CLK_I(clk), .RST_I(rst_a_n), .up(if_a),
    .lcd_rs(lcd_rs_a), .lcd_e(lcd_e_a), .lcd_data(lcd_data_a), .dbg_state(dbg_a)
  );

  hd44780_byte_sender #(
    .TICKS_TAS(1), .TICKS_PWEH(2), .TICKS_TCYCE(5), .COUNT_BITS(3),
    .TICKS_EXEC(0), .EXEC_BITS(4)
  ) u_b (
    .CLK_I(clk), .RST_I(rst_b_n), .up(if_b),
    .lcd_rs(lcd_rs_b), .lcd_e(lcd_e_b), .lcd_data(lcd_data_b), .dbg_state(dbg_b)
  );

  int cfg_tas   [2] = '{3, 1};
  int cfg_pweh  [2] = '{22, 2};
  int cfg_tcyce [2] = '{48, 5};
  int cfg_exec  [2] = '{2544, 0};

  // ---------------- scoreboard state ----------------
  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  logic       last_rs   [2];
  logic [3:0] last_data [2];

  // Observed vector: {busy, end_strobe, lcd_e, lcd_rs, lcd_data}
  function automatic logic [7:0] obs(int sel);
    if (sel == 0) return {if_a.busy, if_a.end_strobe, lcd_e_a, lcd_rs_a, lcd_data_a};
    return {if_b.busy, if_b.end_strobe, lcd_e_b, lcd_rs_b, lcd_data_b};
  endfunction

  // Reference: clock k after acceptance; each nybble occupies one TCYCE window,
  // E is high inside [TAS, TAS+PWEH) of the window, then the exec wait, then one done clock.
  function automatic logic [7:0] model_at(int sel, int k, logic [7:0] d, logic rs, logic nyb);
    int n_nyb, len, idx, p;
    logic e;
    logic [3:0] nd;
    n_nyb = nyb ? 1 : 2;
    len   = n_nyb * cfg_tcyce[sel] + cfg_exec[sel] + 1;
    idx   = (k - 1) / cfg_tcyce[sel];
    p     = (k - 1) % cfg_tcyce[sel];
    if (k == len) return {1'b0, 1'b1, 1'b0, rs, (n_nyb == 2) ? d[3:0] : d[7:4]};
    if (idx < n_nyb) begin
      e  = (p >= cfg_tas[sel]) && (p < cfg_tas[sel] + cfg_pweh[sel]);
      nd = (idx == 0) ? d[7:4] : d[3:0];
      return {1'b1, 1'b0, e, rs, nd};
    end
    return {1'b1, 1'b0, 1'b0, rs, (n_nyb == 2) ? d[3:0] : d[7:4]};
  endfunction

  task automatic check(string tag, logic [7:0] o, logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(int sel, logic st, logic [7:0] d, logic rs, logic nyb);
    if (sel == 0) begin
      if_a.start_strobe = st; if_a.DAT_I = d; if_a.rs_i = rs; if_a.nyb_only_i = nyb;
    end else begin
      if_b.start_strobe = st; if_b.DAT_I = d; if_b.rs_i = rs; if_b.nyb_only_i = nyb;
    end
  endtask

  task automatic drive_strobe(int sel, logic st);
    if (sel == 0) if_a.start_strobe = st;
    else          if_b.start_strobe = st;
  endtask

  task automatic set_rst(int sel, logic v);
    if (sel == 0) rst_a_n = v;
    else          rst_b_n = v;
  endtask

  // Called at a negedge; returns at the negedge before the done clock's edge.
  // glitch: scramble inputs after acceptance and re-pulse start_strobe mid-transfer.
  // abort_k: nonzero asserts reset right after the check at clock abort_k.
  task automatic xfer(int sel, logic [7:0] d, logic rs, logic nyb, bit glitch, int abort_k);
    int len, gk;
    string tag;
    logic [7:0] e;
    tag = (sel == 0) ? "xfer_a" : "xfer_b";
    len = (nyb ? 1 : 2) * cfg_tcyce[sel] + cfg_exec[sel] + 1;
    gk  = (len > 12) ? 10 : 2;
    exp_q.delete();
    for (int k = 1; k <= len; k++) exp_q.push_back(model_at(sel, k, d, rs, nyb));
    drive(sel, 1'b1, d, rs, nyb);
    @(posedge clk);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (glitch) drive(sel, 1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        else        drive_strobe(sel, 1'b0);
      end
      if (glitch && k == gk)     drive_strobe(sel, 1'b1);
      if (glitch && k == gk + 1) drive_strobe(sel, 1'b0);
      e = exp_q.pop_front();
      check(tag, obs(sel), e);
      if (k == abort_k) begin
        set_rst(sel, 1'b0);
        break;
      end
    end
    last_rs[sel]   = rs;
    last_data[sel] = nyb ? d[7:4] : d[3:0];
  endtask

  task automatic idle_cycles(int sel, int n, string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, obs(sel), {3'b000, last_rs[sel], last_data[sel]});
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] d;
    logic       rs, nyb;
    bit         gl;
    int         gap;
    checks = 0;
    errors = 0;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", obs(0), 8'h00);
    check("reset_b", obs(1), 8'h00);
    check("reset_state_a", 8'(dbg_a), 8'(ST_IDLE));
    check("reset_state_b", 8'(dbg_b), 8'(ST_IDLE));
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      last_rs[s]   = 1'b0;
      last_data[s] = 4'h0;
    end
    @(negedge clk);

    // Default timing: full byte, lone nybble, back-to-back with mid-transfer noise
    xfer(0, 8'h38, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(0, 3, "idle_a_after_byte");
    xfer(0, 8'h30, 1'b0, 1'b1, 1'b0, 0);
    xfer(0, 8'hC5, 1'b1, 1'b0, 1'b1, 0);
    idle_cycles(0, 2, "idle_a_after_b2b");

    // Reset while E is high aborts without completion
    xfer(0, 8'h38, 1'b0, 1'b0, 1'b0, 60);
    @(negedge clk);
    check("reset_abort_pins", obs(0), 8'h00);
    check("reset_abort_state", 8'(dbg_a), 8'(ST_IDLE));
    rst_a_n = 1'b1;
    last_rs[0]   = 1'b0;
    last_data[0] = 4'h0;
    idle_cycles(0, 200, "idle_a_after_abort");
    xfer(0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0);

    // Long idle: no E pulse, no completion
    idle_cycles(0, 10000, "idle_a_long");

    // Short timing: directed byte then randomized traffic with random gaps
    xfer(1, 8'hA5, 1'b1, 1'b0, 1'b0, 0);
    idle_cycles(1, 2, "idle_b_after_a5");
    for (int t = 0; t < 60; t++) begin
      d   = 8'($urandom_range(0, 255));
      rs  = 1'($urandom_range(0, 1));
      nyb = 1'($urandom_range(0, 1));
      gl  = 1'($urandom_range(0, 1));
      xfer(1, d, rs, nyb, gl, 0);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle_cycles(1, gap, "idle_b_gap");
    end
    idle_cycles(1, 3, "idle_b_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
